// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset sequencer: state
// encodings, opcode constants and ALUOp codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_LD = 4'd6,
        S_MEM_ST = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_ERROR  = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRCMP  = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    // States that hold a request on the shared memory port.
    function automatic logic is_mem_req(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_LD) || (s == S_MEM_ST);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts unanswered request cycles and flags the
// MEM_TIMEOUT-th consecutive one, so the FSM can give up on the memory.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic busy,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (busy && (cnt_q != '1)) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the misses before this cycle; a miss now makes MEM_TIMEOUT.
    assign expired = busy && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multi-cycle control FSM for an RV32I subset (R, I-ALU, load,
// store, branch). Optional MULTICYCLE_ILLEGAL_TRAP_EN traps unsupported opcodes.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCBranchWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       Branch,
    output logic       MemError,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    output logic       IllegalInstr,
`endif
    output logic [3:0] StateOut
);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] op_q;
    logic [6:0] op_d;
    logic       wait_clear;
    logic       wait_busy;
    logic       wait_expired;

    assign wait_busy  = is_mem_req(state_q) && !MemReady;
    // Any state change is an entry into the new state, so the count restarts.
    assign wait_clear = (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .WAIT_W     (WAIT_W)
    ) u_wait (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (wait_clear),
        .busy   (wait_busy),
        .expired(wait_expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (MemReady)          state_d = S_DECODE;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_DECODE: begin
                op_d = Opcode;
                case (Opcode)
                    OP_R_TYPE:          state_d = S_EXEC_R;
                    OP_I_ALU:           state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:            state_d = S_TRAP;
`else
                    default:            state_d = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
            S_ADDR: state_d = (op_q == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
            S_MEM_LD: begin
                if (MemReady)          state_d = S_WB_MEM;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_MEM_ST: begin
                if (MemReady)          state_d = S_FETCH;
                else if (wait_expired) state_d = S_ERROR;
            end
            S_ERROR, S_TRAP: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Decoded from the registered state, so Reset clears outputs asynchronously.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_ADD;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        Branch   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_EXEC_R: ALUOp = ALU_RFUNCT;
            S_EXEC_I: begin
                ALUSrc = 1'b1;
                ALUOp  = ALU_IFUNCT;
            end
            S_WB_ALU: RegWrite = 1'b1;
            S_ADDR:   ALUSrc = 1'b1;
            S_MEM_LD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_ST: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_BRANCH: begin
                Branch = 1'b1;
                ALUOp  = ALU_BRCMP;
            end
            default: ;
        endcase
    end

    assign PCBranchWrite = Branch & Zero;
    assign MemError      = (state_q == S_ERROR);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    assign IllegalInstr  = (state_q == S_TRAP);
`endif
    assign StateOut      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each task drives one scenario
// cycle by cycle and compares state and control outputs against hand values.
module tb_multicycle_control;
    import multicycle_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [6:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCBranchWrite, IRWrite, IorD, MemRead, MemWrite;
    logic       ALUSrc, RegWrite, MemToReg, Branch, MemError;
    logic [1:0] ALUOp;
    logic [3:0] StateOut;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic       IllegalInstr;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_control #(.MEM_TIMEOUT(15), .WAIT_W(8)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Opcode       (Opcode),
        .Zero         (Zero),
        .MemReady     (MemReady),
        .PCWrite      (PCWrite),
        .PCBranchWrite(PCBranchWrite),
        .IRWrite      (IRWrite),
        .IorD         (IorD),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .ALUSrc       (ALUSrc),
        .ALUOp        (ALUOp),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .Branch       (Branch),
        .MemError     (MemError),
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        .IllegalInstr (IllegalInstr),
`endif
        .StateOut     (StateOut)
    );

    always #5 Clock = ~Clock;

    // {PCWrite,PCBranchWrite,IRWrite,IorD,MemRead,MemWrite,ALUSrc,ALUOp,RegWrite,MemToReg,Branch,MemError}
    logic [12:0] ctrl;
    assign ctrl = {PCWrite, PCBranchWrite, IRWrite, IorD, MemRead, MemWrite,
                   ALUSrc, ALUOp, RegWrite, MemToReg, Branch, MemError};

    localparam logic [12:0] C_NONE    = 13'b0_0_0_0_0_0_0_00_0_0_0_0;
    localparam logic [12:0] C_FETCH   = 13'b0_0_0_0_1_0_0_00_0_0_0_0;
    localparam logic [12:0] C_FETCH_R = 13'b1_0_1_0_1_0_0_00_0_0_0_0;
    localparam logic [12:0] C_EXEC_R  = 13'b0_0_0_0_0_0_0_10_0_0_0_0;
    localparam logic [12:0] C_EXEC_I  = 13'b0_0_0_0_0_0_1_11_0_0_0_0;
    localparam logic [12:0] C_WB_ALU  = 13'b0_0_0_0_0_0_0_00_1_0_0_0;
    localparam logic [12:0] C_ADDR    = 13'b0_0_0_0_0_0_1_00_0_0_0_0;
    localparam logic [12:0] C_MEM_LD  = 13'b0_0_0_1_1_0_0_00_0_0_0_0;
    localparam logic [12:0] C_WB_MEM  = 13'b0_0_0_0_0_0_0_00_1_1_0_0;
    localparam logic [12:0] C_MEM_ST  = 13'b0_0_0_1_0_1_0_00_0_0_0_0;
    localparam logic [12:0] C_BR_T    = 13'b0_1_0_0_0_0_0_01_0_0_1_0;
    localparam logic [12:0] C_BR_N    = 13'b0_0_0_0_0_0_0_01_0_0_1_0;
    localparam logic [12:0] C_ERR     = 13'b0_0_0_0_0_0_0_00_0_0_0_1;

    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic        rdy;
        logic        zero;
        logic [6:0]  op;
        state_t      st;
        logic [12:0] ctl;
    } row_t;

    // Read port and write port requests must never overlap.
    always @(negedge Clock) begin
        checks++;
        if (MemRead && MemWrite) begin
            errors++;
            $display("FAIL excl: MemRead=%0b MemWrite=%0b both high", MemRead, MemWrite);
        end
    end

    // Reset asserted over two falling edges, released at a falling edge: DUT sits in IDLE.
    task automatic do_reset();
        Reset = 1'b1; MemReady = 1'b0; Zero = 1'b0; Opcode = '0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // One cycle: wait for the edge, apply this cycle's inputs, let outputs settle.
    task automatic step(input logic rdy, input logic zero, input logic [6:0] op);
        @(posedge Clock); #1;
        MemReady = rdy; Zero = zero; Opcode = op;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; MemReady = 1'b1; Zero = 1'b1; Opcode = OP_R_TYPE;
        #12;
        checks++;
        if (StateOut !== 4'(S_IDLE)) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", StateOut, S_IDLE);
        end
        checks++;
        if (ctrl !== C_NONE) begin
            errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_NONE);
        end
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checks++;
        if (StateOut !== 4'(S_IDLE)) begin
            errors++; $display("FAIL reset_release_idle: got %0d want %0d", StateOut, S_IDLE);
        end
        step(1'b0, 1'b0, '0);
        checks++;
        if (StateOut !== 4'(S_FETCH)) begin
            errors++; $display("FAIL reset_to_fetch: got %0d want %0d", StateOut, S_FETCH);
        end
    endtask

    task automatic test_back_to_back();
        row_t rows [17];
        rows = '{
            '{1'b1, 1'b0, OP_R_TYPE, S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b0, OP_R_TYPE, S_DECODE, C_NONE},
            '{1'b0, 1'b0, OP_R_TYPE, S_EXEC_R, C_EXEC_R},
            '{1'b0, 1'b0, OP_R_TYPE, S_WB_ALU, C_WB_ALU},
            '{1'b1, 1'b0, OP_I_ALU,  S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b0, OP_I_ALU,  S_DECODE, C_NONE},
            '{1'b0, 1'b0, OP_I_ALU,  S_EXEC_I, C_EXEC_I},
            '{1'b0, 1'b0, OP_I_ALU,  S_WB_ALU, C_WB_ALU},
            '{1'b0, 1'b0, OP_STORE,  S_FETCH,  C_FETCH},
            '{1'b1, 1'b0, OP_STORE,  S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b0, OP_STORE,  S_DECODE, C_NONE},
            '{1'b0, 1'b0, OP_STORE,  S_ADDR,   C_ADDR},
            '{1'b1, 1'b0, OP_STORE,  S_MEM_ST, C_MEM_ST},
            '{1'b1, 1'b1, OP_BRANCH, S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b1, OP_BRANCH, S_DECODE, C_NONE},
            '{1'b0, 1'b1, OP_BRANCH, S_BRANCH, C_BR_T},
            '{1'b0, 1'b0, OP_BRANCH, S_FETCH,  C_FETCH}
        };
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(rows[i].rdy, rows[i].zero, rows[i].op);
            checks++;
            if (StateOut !== 4'(rows[i].st)) begin
                errors++; $display("FAIL b2b[%0d] state: got %0d want %0d", i, StateOut, rows[i].st);
            end
            checks++;
            if (ctrl !== rows[i].ctl) begin
                errors++; $display("FAIL b2b[%0d] ctrl: got %b want %b", i, ctrl, rows[i].ctl);
            end
        end
    endtask

    task automatic test_load_wait();
        row_t rows [9];
        rows = '{
            '{1'b1, 1'b0, OP_LOAD, S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b0, OP_LOAD, S_DECODE, C_NONE},
            '{1'b0, 1'b0, OP_LOAD, S_ADDR,   C_ADDR},
            '{1'b0, 1'b0, OP_LOAD, S_MEM_LD, C_MEM_LD},
            '{1'b0, 1'b0, OP_LOAD, S_MEM_LD, C_MEM_LD},
            '{1'b0, 1'b0, OP_LOAD, S_MEM_LD, C_MEM_LD},
            '{1'b1, 1'b0, OP_LOAD, S_MEM_LD, C_MEM_LD},
            '{1'b0, 1'b0, OP_LOAD, S_WB_MEM, C_WB_MEM},
            '{1'b0, 1'b0, OP_LOAD, S_FETCH,  C_FETCH}
        };
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(rows[i].rdy, rows[i].zero, rows[i].op);
            checks++;
            if (StateOut !== 4'(rows[i].st)) begin
                errors++; $display("FAIL load[%0d] state: got %0d want %0d", i, StateOut, rows[i].st);
            end
            checks++;
            if (ctrl !== rows[i].ctl) begin
                errors++; $display("FAIL load[%0d] ctrl: got %b want %b", i, ctrl, rows[i].ctl);
            end
        end
    endtask

    task automatic test_branch();
        row_t rows [7];
        rows = '{
            '{1'b1, 1'b1, OP_BRANCH, S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b1, OP_BRANCH, S_DECODE, C_NONE},
            '{1'b0, 1'b1, OP_BRANCH, S_BRANCH, C_BR_T},
            '{1'b1, 1'b0, OP_BRANCH, S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b0, OP_BRANCH, S_DECODE, C_NONE},
            '{1'b0, 1'b0, OP_BRANCH, S_BRANCH, C_BR_N},
            '{1'b0, 1'b1, OP_BRANCH, S_FETCH,  C_FETCH}
        };
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(rows[i].rdy, rows[i].zero, rows[i].op);
            checks++;
            if (StateOut !== 4'(rows[i].st)) begin
                errors++; $display("FAIL branch[%0d] state: got %0d want %0d", i, StateOut, rows[i].st);
            end
            checks++;
            if (ctrl !== rows[i].ctl) begin
                errors++; $display("FAIL branch[%0d] ctrl: got %b want %b", i, ctrl, rows[i].ctl);
            end
        end
    endtask

    // 15 unanswered FETCH cycles, then ERROR; ERROR ignores MemReady until Reset.
    task automatic test_timeout();
        state_t      exp_st;
        logic [12:0] exp_ctl;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(i >= 16, 1'b0, OP_R_TYPE);
            exp_st  = (i < 15) ? S_FETCH : S_ERROR;
            exp_ctl = (i < 15) ? C_FETCH : C_ERR;
            checks++;
            if (StateOut !== 4'(exp_st)) begin
                errors++; $display("FAIL timeout[%0d] state: got %0d want %0d", i, StateOut, exp_st);
            end
            checks++;
            if (ctrl !== exp_ctl) begin
                errors++; $display("FAIL timeout[%0d] ctrl: got %b want %b", i, ctrl, exp_ctl);
            end
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (MemError !== 1'b0 || StateOut !== 4'(S_IDLE)) begin
            errors++; $display("FAIL timeout_clear: MemError=%0b state=%0d want 0/%0d", MemError, StateOut, S_IDLE);
        end
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Ready on the 15th request cycle beats the timeout; the count restarts per FETCH.
    task automatic test_timeout_boundary();
        do_reset();
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 15; i++) begin
                step(i == 14, 1'b0, OP_R_TYPE);
                checks++;
                if (StateOut !== 4'(S_FETCH) || ctrl !== ((i == 14) ? C_FETCH_R : C_FETCH)) begin
                    errors++;
                    $display("FAIL bound[%0d.%0d]: state=%0d ctrl=%b want %0d/%b", round, i,
                             StateOut, ctrl, S_FETCH, (i == 14) ? C_FETCH_R : C_FETCH);
                end
            end
            step(1'b0, 1'b0, OP_R_TYPE);
            checks++;
            if (StateOut !== 4'(S_DECODE)) begin
                errors++; $display("FAIL bound_decode[%0d]: got %0d want %0d", round, StateOut, S_DECODE);
            end
            step(1'b0, 1'b0, OP_R_TYPE);
            step(1'b0, 1'b0, OP_R_TYPE);
        end
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        step(1'b1, 1'b0, OP_STORE);
        step(1'b0, 1'b0, OP_STORE);
        step(1'b0, 1'b0, OP_STORE);
        step(1'b0, 1'b0, OP_STORE);
        checks++;
        if (StateOut !== 4'(S_MEM_ST) || MemWrite !== 1'b1) begin
            errors++; $display("FAIL midst_pre: state=%0d MemWrite=%0b want %0d/1", StateOut, MemWrite, S_MEM_ST);
        end
        #1;
        Reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || ctrl !== C_NONE) begin
            errors++; $display("FAIL midst_async: MemWrite=%0b ctrl=%b want 0/%b", MemWrite, ctrl, C_NONE);
        end
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checks++;
        if (StateOut !== 4'(S_IDLE)) begin
            errors++; $display("FAIL midst_idle: got %0d want %0d", StateOut, S_IDLE);
        end
        step(1'b0, 1'b0, OP_STORE);
        checks++;
        if (StateOut !== 4'(S_FETCH) || ctrl !== C_FETCH) begin
            errors++; $display("FAIL midst_fetch: state=%0d ctrl=%b want %0d/%b", StateOut, ctrl, S_FETCH, C_FETCH);
        end
    endtask

    task automatic test_illegal();
        row_t rows [5];
        logic exp_ill;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        rows = '{
            '{1'b1, 1'b0, OP_BAD, S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b0, OP_BAD, S_DECODE, C_NONE},
            '{1'b1, 1'b0, OP_BAD, S_TRAP,   C_NONE},
            '{1'b1, 1'b1, OP_BAD, S_TRAP,   C_NONE},
            '{1'b0, 1'b0, OP_BAD, S_TRAP,   C_NONE}
        };
`else
        rows = '{
            '{1'b1, 1'b0, OP_BAD, S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b0, OP_BAD, S_DECODE, C_NONE},
            '{1'b1, 1'b0, OP_BAD, S_FETCH,  C_FETCH_R},
            '{1'b0, 1'b0, OP_BAD, S_DECODE, C_NONE},
            '{1'b0, 1'b0, OP_BAD, S_FETCH,  C_FETCH}
        };
`endif
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(rows[i].rdy, rows[i].zero, rows[i].op);
            checks++;
            if (StateOut !== 4'(rows[i].st)) begin
                errors++; $display("FAIL illegal[%0d] state: got %0d want %0d", i, StateOut, rows[i].st);
            end
            checks++;
            if (ctrl !== rows[i].ctl) begin
                errors++; $display("FAIL illegal[%0d] ctrl: got %b want %b", i, ctrl, rows[i].ctl);
            end
            exp_ill = (rows[i].st == S_TRAP);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            checks++;
            if (IllegalInstr !== exp_ill) begin
                errors++; $display("FAIL illegal[%0d] flag: got %0b want %0b", i, IllegalInstr, exp_ill);
            end
`else
            checks++;
            if (exp_ill !== 1'b0 && StateOut !== 4'(S_FETCH)) begin
                errors++; $display("FAIL illegal[%0d] trap row without trap build", i);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_wait();
        test_branch();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_store();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
